// File: rtl/sn76489_control.sv
// sn76489_control: PSG byte-write decode, noise divider select, /16 enable.
// Define SN76489_READY_EN to build the BUSY_CYCLES write-busy counter.
module sn76489_control #(
  parameter int BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] data,
  output logic       ready,
  output logic       enable,
  output logic [9:0] tone0_n,
  output logic [9:0] tone1_n,
  output logic [9:0] tone2_n,
  output logic [3:0] att0,
  output logic [3:0] att1,
  output logic [3:0] att2,
  output logic [3:0] att3,
  output logic [9:0] noise_n,
  output logic       noiseFeedbackType,
  output logic       noise_rst
);

  logic [9:0] tone [3];
  logic [3:0] att  [4];
  logic [1:0] nf;
  logic       fb;
  logic [1:0] latch_ch;
  logic       latch_type;
  logic [3:0] cnt;

  logic       acc;
  logic [1:0] tgt_ch;
  logic       tgt_type;
  logic       tone_we;
  logic       att_we;
  logic       noise_we;

  assign acc = wr & ready;

  // Resolve which register this byte targets.
  always_comb begin
    tgt_ch   = latch_ch;
    tgt_type = latch_type;
    tone_we  = 1'b0;
    att_we   = 1'b0;
    noise_we = 1'b0;
    if (data[7]) begin
      tgt_ch   = data[6:5];
      tgt_type = data[4];
    end
    if (acc) begin
      unique case (1'b1)
        tgt_type:
          att_we = 1'b1;
        !tgt_type && (tgt_ch == 2'd3):
          noise_we = 1'b1;
        !tgt_type && (tgt_ch != 2'd3):
          tone_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Latch byte remembers channel and type.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latch_ch   <= 2'd0;
      latch_type <= 1'b0;
    end else if (acc && data[7]) begin
      latch_ch   <= data[6:5];
      latch_type <= data[4];
    end
  end

  // Tone dividers: latch writes low nibble, data writes upper six.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        tone[i] <= '0;
    end else if (tone_we) begin
      for (int i = 0; i < 3; i++) begin
        if (tgt_ch == 2'(i)) begin
          if (data[7])
            tone[i][3:0] <= data[3:0];
          else
            tone[i][9:4] <= data[5:0];
        end
      end
    end
  end

  // Attenuators, 4'hF is silent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        att[i] <= 4'hF;
    end else if (att_we) begin
      for (int i = 0; i < 4; i++)
        if (tgt_ch == 2'(i))
          att[i] <= data[3:0];
    end
  end

  // Noise control plus a one-cycle LFSR restart per noise write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nf        <= 2'b00;
      fb        <= 1'b0;
      noise_rst <= 1'b0;
    end else begin
      noise_rst <= noise_we;
      if (noise_we) begin
        fb <= data[2];
        nf <= data[1:0];
      end
    end
  end

  // Noise divider follows tone2 live when NF selects it.
  always_comb begin
    noise_n = 10'd32;
    unique case (nf)
      2'b00: noise_n = 10'd32;
      2'b01: noise_n = 10'd64;
      2'b10: noise_n = 10'd128;
      2'b11: noise_n = tone2_n;
      default: noise_n = 10'd32;
    endcase
  end

  // Free-running /16 prescaler for the generators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= 4'd0;
    else
      cnt <= cnt + 4'd1;
  end

  assign enable = (cnt == 4'd15);

`ifdef SN76489_READY_EN
  localparam int BW = $clog2(BUSY_CYCLES + 1);

  logic [BW-1:0] busy;

  // Hold ready low for BUSY_CYCLES after each accepted write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy <= '0;
    else if (acc)
      busy <= BW'(BUSY_CYCLES);
    else if (busy != '0)
      busy <= busy - 1'b1;
  end

  assign ready = (busy == '0);
`else
  assign ready = 1'b1;
`endif

  assign tone0_n           = tone[0];
  assign tone1_n           = tone[1];
  assign tone2_n           = tone[2];
  assign att0              = att[0];
  assign att1              = att[1];
  assign att2              = att[2];
  assign att3              = att[3];
  assign noiseFeedbackType = fb;

endmodule

// File: doc/sn76489_control.md
# sn76489_control

Host-facing control stage of the SN76489 PSG, directly upstream of `sn76489_noise_generator` and the tone generators. It decodes the PSG byte-write protocol into the tone, attenuation and noise registers and derives the noise divider value `n`. It also generates the divide-by-16 `enable` strobe that steps every generator, and a noise-LFSR restart pulse on every noise-register write.

## Interface
Parameters:
- `BUSY_CYCLES`, default 32: clock cycles `ready` stays low after an accepted write (used only when `SN76489_READY_EN` is defined).

Ports:
- `clk`  in  1: system clock; the PSG master clock.
- `reset`  in  1: asynchronous, active-low.
- `wr`  in  1: write strobe; one byte is accepted per cycle in which `wr` is high and the block is not busy.
- `data`  in  8: write byte.
- `ready`  out  1: high when a write would be accepted.
- `enable`  out  1: one-cycle strobe, high 1 cycle in 16.
- `tone0_n`, `tone1_n`, `tone2_n`  out  10 each: tone divider values.
- `att0`, `att1`, `att2`, `att3`  out  4 each: attenuations; 4'hF means off; `att3` is the noise channel.
- `noise_n`  out  10: noise divider value, goes to the generator's `n`.
- `noiseFeedbackType`  out  1: 0 = periodic, 1 = white noise.
- `noise_rst`  out  1: one-cycle pulse that restarts the noise LFSR.

## Operation
Byte decode:
- Latch byte (`data[7]`=1):
  - Stores `latch_ch`=`data[6:5]` and `latch_type`=`data[4]` (1 = attenuation).
  - Writes `data[3:0]` into the addressed register.
  - Tone register: writes the low nibble `n[3:0]` and keeps `n[9:4]`.
  - Attenuation: writes `att`.
  - Noise register: `data[2]` goes to feedback and `data[1:0]` go to NF.
- Data byte (`data[7]`=0):
  - If latched on a tone register: `n[9:4]`=`data[5:0]`, keeping `n[3:0]`.
  - If latched on an attenuation or the noise register: `data[3:0]` is written as in a latch byte.

Noise divider and restart:
- `noise_n` by NF: 00→10'd32, 01→10'd64, 10→10'd128, 11→`tone2_n` (tracks later `tone2_n` changes).
- Any accepted write to the noise register (latch or data byte) makes `noise_rst` high for 1 cycle.
- Writes to other registers never pulse `noise_rst`.

Enable strobe:
- 4-bit free-running counter `cnt`; `enable` = (`cnt`==15).
- Always running; not affected by writes.

Reset values (asserted immediately, while `reset` is low):
- `tone*_n`=0, `att0`..`att3`=4'hF, NF=00, so `noise_n`=32.
- `noiseFeedbackType`=0, `noise_rst`=0, `cnt`=0, `enable`=0.
- `ready`=1, latch state = channel 0 tone.
- A reset mid-busy clears busy.

## Timing
- Write acceptance: a byte is sampled on the rising edge where `wr`=1 and `ready`=1.
- Register outputs change on that edge, so they are visible in the following cycle.
- `noise_rst` is registered: high in the cycle after the accepting edge, for exactly 1 cycle.
- Writes with `ready`=0 are dropped entirely: no register change, no `noise_rst`, latch unchanged.
- Back-to-back writes without `SN76489_READY_EN` are each accepted on consecutive edges.
- `enable` is first high in the 16th cycle after `reset` deasserts, then every 16 cycles.
- `enable` has no dependency on writes; a write and `enable` in the same cycle are both honoured.

## Configuration
- `SN76489_READY_EN` defined:
  - An accepted write drops `ready` at the next edge.
  - A down-counter holds `ready` low for `BUSY_CYCLES` cycles, then `ready` returns to 1.
- `SN76489_READY_EN` undefined:
  - `ready` is tied to 1 and no busy counter is built.
  - Every write with `wr`=1 is accepted.

## Test plan
- Release reset, no writes → `enable` high exactly in cycles 16, 32, 48…; `att0`..`att3`=F; `noise_n`=32; `noiseFeedbackType`=0; `ready`=1.
- Write 0x8F then 0x3F → `tone0_n`=10'h3FF. Then write 0x80 → `tone0_n`=10'h3F0.
- Write 0xE5 → `noiseFeedbackType`=1, `noise_n`=64, `noise_rst` high 1 cycle. Then 0xE7 after `tone2_n` set to 300 by 0xCC, 0x12 → `noise_n`=300.
- Write 0x9A → `att0`=A. Then data byte 0x03 → `att0`=3, with no tone change and no `noise_rst`.
- `SN76489_READY_EN` defined: write 0x91, then 0x92 two cycles later → second write ignored, `att0`=1, `ready` low for 32 cycles.
- Assert reset mid-busy after writes → all outputs return to reset values at once, `ready`=1.
